// File: rtl/uart_rx_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_buffer_pkg
// Description : Shared constants and types for the UART receive buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_buffer_pkg;

    // Width of one UART data frame
    localparam int UART_DW       = 8;
    // Default number of FIFO entries
    localparam int DEFAULT_DEPTH = 16;
    // Width of the saturating framing-error counter
    localparam int ERRCNT_W      = 8;

    typedef logic [UART_DW-1:0]  uart_byte_t;
    typedef logic [ERRCNT_W-1:0] err_cnt_t;

endpackage : uart_rx_buffer_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_mem
// Description : DEPTH x 8 storage array, one synchronous write port and one
//               asynchronous read port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo_mem
    import uart_rx_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  uart_byte_t    i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output uart_byte_t    o_rd_data
);

    uart_byte_t r_mem [DEPTH];

    // Capture the incoming byte at the write address on the active edge
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Head entry is visible without a clock (first-word-fall-through)
    assign o_rd_data = r_mem[i_rd_addr];

endmodule : uart_rx_fifo_mem
`default_nettype wire

// File: rtl/uart_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_buffer
// Description : Receive-side FIFO between a UART Rx FSM and its consumer.
//               Good frames are queued, framing-error frames are discarded,
//               a write into a full FIFO without a same-cycle pop sets a
//               sticky overrun flag. Output is first-word-fall-through.
//               Optional macro UART_RX_ERRCNT_EN adds a saturating 8-bit
//               framing-error counter on port o_err_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_buffer
    import uart_rx_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    i_rx_d,
    input  logic          i_rx_complete,
    input  logic          i_rx_error,
    input  logic          i_rd_en,
    input  logic          i_ovr_clr,
    output logic [7:0]    o_rd_d,
    output logic          o_rd_valid,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count,
    output logic          o_overrun
`ifdef UART_RX_ERRCNT_EN
    ,
    output logic [7:0]    o_err_cnt
`endif
);

    localparam logic [AW:0] C_FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overrun;

    logic          w_full;
    logic          w_empty;
    logic          w_wr_req;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    // Flags come straight from the registered occupancy
    assign w_full   = (r_count == C_FULL_CNT);
    assign w_empty  = (r_count == '0);

    // A frame with a stop-bit error is never stored, even if complete is high
    assign w_wr_req = i_rx_complete & ~i_rx_error;
    // Pops on an empty FIFO are ignored
    assign w_pop    = i_rd_en & ~w_empty;
    // A same-cycle pop frees the slot the write needs when full
    assign w_push   = w_wr_req & (~w_full | w_pop);
    assign w_drop   = w_wr_req & ~w_push;

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (i_rx_d),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (o_rd_d)
    );

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Sticky overrun: a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (i_ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

`ifdef UART_RX_ERRCNT_EN
    err_cnt_t r_err_cnt;

    // Count framing errors, holding at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (i_rx_error && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign o_err_cnt = r_err_cnt;
`endif

    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_rd_valid = ~w_empty;
    assign o_overrun  = r_overrun;

endmodule : uart_rx_buffer
`default_nettype wire

// File: doc/uart_rx_buffer.md
UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 4..256).
REQ-002 SHALL have parameter AW, default 4, pointer width = log2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_rx_d  input  8  received byte from the UART Rx FSM, stable while i_rx_complete is high.
REQ-006 SHALL have port i_rx_complete  input  1  one-cycle pulse: valid frame on i_rx_d.
REQ-007 SHALL have port i_rx_error  input  1  one-cycle pulse: frame failed its stop-bit check.
REQ-008 SHALL have port i_rd_en  input  1  consumer pop request.
REQ-009 SHALL have port i_ovr_clr  input  1  clears the sticky overrun flag.
REQ-010 SHALL have port o_rd_d  output  8  head-of-FIFO byte (first-word-fall-through).
REQ-011 SHALL have port o_rd_valid  output  1  high when FIFO not empty.
REQ-012 SHALL have port o_full  output  1  count == DEPTH.
REQ-013 SHALL have port o_empty  output  1  count == 0.
REQ-014 SHALL have port o_count  output  AW+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have port o_overrun  output  1  sticky: a byte was dropped.
REQ-016 SHALL have port o_err_cnt  output  8  framing-error count (present only with UART_RX_ERRCNT_EN).

Function
REQ-017 SHALL write i_rx_d at wr_ptr on the clock edge where i_rx_complete=1, i_rx_error=0 and the FIFO is not full or a pop occurs in the same cycle.
REQ-018 SHALL pop on the edge where i_rd_en=1 and o_rd_valid=1; i_rd_en while empty SHALL be ignored (no pointer or count change).
REQ-019 SHALL present o_rd_d = mem[rd_ptr] combinationally from registered pointers; a written byte is visible on o_rd_d and o_rd_valid the cycle after the write edge.
REQ-020 SHALL wrap wr_ptr and rd_ptr modulo DEPTH; occupancy SHALL come from a separate AW+1-bit counter.
REQ-021 Write and pop in the same cycle SHALL leave o_count unchanged; when full, a same-cycle pop SHALL make the write legal (no overrun).
REQ-022 Write and pop in the same cycle while empty SHALL perform the write only (count 0->1).
REQ-023 A write while full without pop SHALL drop the byte, leave memory, pointers and count unchanged, and set o_overrun.
REQ-024 o_overrun SHALL stay set until i_ovr_clr=1; set and clear in the same cycle SHALL leave it set.
REQ-025 i_rx_error=1 SHALL never write the FIFO; with i_rx_complete and i_rx_error high together, error SHALL win.
REQ-026 o_full, o_empty, o_rd_valid SHALL be decoded from the registered count (no extra latency beyond REQ-019).

Reset
REQ-027 On rst_n=0, at any time including mid-write, SHALL asynchronously clear wr_ptr, rd_ptr, count, o_overrun, o_err_cnt; o_empty=1, o_full=0, o_rd_valid=0, o_count=0.
REQ-028 Memory contents SHALL NOT be reset; o_rd_d is don't-care while o_rd_valid=0.

Configuration
REQ-029 With UART_RX_ERRCNT_EN defined, o_err_cnt SHALL increment by 1 per i_rx_error pulse, saturating at 255, cleared only by reset.
REQ-030 Without UART_RX_ERRCNT_EN, port o_err_cnt and its counter SHALL be absent; i_rx_error still blocks writes per REQ-025.

Structure
REQ-031 Shared package SHALL hold UART data width (8), default DEPTH (16) and error-counter width (8).
REQ-032 Storage SHALL be one sub-module uart_rx_fifo_mem (DEPTH x 8, one synchronous write port, one asynchronous read port); pointer/count/flag logic stays in uart_rx_buffer.

Verification
REQ-033 Reset, write 0x55,0xAA,0x0F -> o_count=3, o_rd_d=0x55; three pops return 0x55,0xAA,0x0F, then o_empty=1.
REQ-034 Write 16 bytes 0x00..0x0F, then 0x99 without pop -> o_full=1, o_overrun=1, count=16, pops return 0x00..0x0F only.
REQ-035 Full FIFO, write 0x77 with i_rd_en same cycle -> o_overrun=0, count=16, last byte popped after 15 others is 0x77.
REQ-036 Empty FIFO, i_rd_en with write 0x3C same cycle -> count=1, o_rd_d=0x3C; i_rd_en alone on empty -> count stays 0.
REQ-037 300 i_rx_error pulses (one with i_rx_complete) with macro -> o_err_cnt=255, FIFO empty; without macro -> FIFO empty, port absent.
REQ-038 Assert rst_n=0 with count=5 and o_overrun=1, i_ovr_clr and set same cycle earlier kept flag -> after reset count=0, o_overrun=0, o_empty=1.
